// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES inverse-cipher control path: FSM states,
// stage one-hot encodings, round-count constants and the stage decoder.
package aes_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // Position of a stage within one inverse round
    typedef enum logic [1:0] {
        POS_SR  = 2'd0,
        POS_SB  = 2'd1,
        POS_ARK = 2'd2,
        POS_IMC = 2'd3
    } pos_t;

    localparam int KEY_IDX_W = 4;
    localparam int NR_128    = 10;
    localparam int NR_256    = 14;

    localparam logic [3:0] STG_SR  = 4'b0001;
    localparam logic [3:0] STG_SB  = 4'b0010;
    localparam logic [3:0] STG_ARK = 4'b0100;
    localparam logic [3:0] STG_IMC = 4'b1000;

    function automatic logic [3:0] pos_to_stage(input pos_t pos);
        logic [3:0] stage;
        case (pos)
            POS_SR:  stage = STG_SR;
            POS_SB:  stage = STG_SB;
            POS_ARK: stage = STG_ARK;
            POS_IMC: stage = STG_IMC;
            default: stage = 4'b0000;
        endcase
        return stage;
    endfunction

endpackage

// File: rtl/aes_stage_timer.sv
// L-cycle window timer: reloads at the start of each stage and flags the
// final cycle of the window.
module aes_stage_timer
    import aes_dec_pkg::*;
#(
    parameter int L = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_load,
    output logic o_last
);

    localparam int CW = $clog2(L + 1);

    logic [CW-1:0] r_cnt;

    // Down-counter: load L for the coming window, count towards one
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(L);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Sequencer for the iterative AES inverse-cipher round datapath: walks the
// shared stage units through ARK(NR), (SR,SB,ARK,IMC) x NR-1, SR,SB,ARK(0).
module aes_inv_round_ctrl
    import aes_dec_pkg::*;
#(
    parameter int NR = 10,
    parameter int L  = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic                 i_flush,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic                 o_load_state,
    output logic [3:0]           o_stage_en,
    output logic                 o_state_we,
    output logic [KEY_IDX_W-1:0] o_key_idx,
    output logic                 o_busy
);

    localparam logic [3:0] NR_L = 4'(NR);

    fsm_state_t           r_state;
    fsm_state_t           w_state_nxt;
    pos_t                 r_pos;
    pos_t                 w_pos_nxt;
    logic [3:0]           r_round;
    logic [3:0]           w_round_nxt;
    logic [3:0]           w_round_dec;
    logic [KEY_IDX_W-1:0] r_key_idx;
    logic [KEY_IDX_W-1:0] w_key_nxt;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_final_stage;
    logic                 w_timer_load;

    assign w_accept      = i_in_valid & (r_state == ST_IDLE) & ~i_flush;
    assign w_final_stage = (r_pos == POS_ARK) && (r_round == 4'd0);
    assign w_round_dec   = (r_round == 4'd0) ? 4'd0 : (r_round - 4'd1);
    assign w_timer_load  = w_accept |
                           ((r_state == ST_RUN) & w_last & ~w_final_stage);

    aes_stage_timer #(
        .L(L)
    ) u_timer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (i_flush),
        .i_load  (w_timer_load),
        .o_last  (w_last)
    );

    // State, schedule position, round and key-index registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_pos     <= POS_SR;
            r_round   <= 4'd0;
            r_key_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pos     <= w_pos_nxt;
            r_round   <= w_round_nxt;
            r_key_idx <= w_key_nxt;
        end
    end

    // Next-state and schedule stepping; stages advance only on the window's last cycle
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_round_nxt = r_round;
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        w_state_nxt = ST_RUN;
                        w_pos_nxt   = POS_ARK;
                        w_round_nxt = NR_L;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        case (r_pos)
                            POS_SR:  w_pos_nxt = POS_SB;
                            POS_SB:  w_pos_nxt = POS_ARK;
                            POS_ARK: begin
                                if (r_round == 4'd0) begin
                                    w_state_nxt = ST_DONE;
                                end else if (r_round == NR_L) begin
                                    // The opening ARK has no IMC after it
                                    w_round_nxt = w_round_dec;
                                    w_pos_nxt   = POS_SR;
                                end else begin
                                    w_pos_nxt = POS_IMC;
                                end
                            end
                            POS_IMC: begin
                                w_round_nxt = w_round_dec;
                                w_pos_nxt   = POS_SR;
                            end
                            default: w_state_nxt = ST_IDLE;
                        endcase
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Key index tracks the round of the upcoming ARK and holds otherwise
    always_comb begin
        if ((w_state_nxt == ST_RUN) && (w_pos_nxt == POS_ARK)) begin
            w_key_nxt = w_round_nxt;
        end else begin
            w_key_nxt = r_key_idx;
        end
    end

    // Output decode from registered state; only load_state sees inputs
    always_comb begin
        o_in_ready   = (r_state == ST_IDLE);
        o_busy       = (r_state == ST_RUN);
        o_out_valid  = (r_state == ST_DONE);
        o_load_state = w_accept;
        o_key_idx    = r_key_idx;
        if (r_state == ST_RUN) begin
            o_stage_en = pos_to_stage(r_pos);
            o_state_we = w_last;
        end else begin
            o_stage_en = 4'b0000;
            o_state_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl: two instances (NR=10/L=1 and
// NR=14/L=3) checked cycle by cycle against a queued expected schedule.
module tb_aes_inv_round_ctrl;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] key;
        logic       we;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic in_valid = 1'b0;
    logic flush = 1'b0;
    logic out_ready = 1'b0;

    logic       iv_a, iv_b, fl_a, fl_b;
    logic       rdy_a, rdy_b, ov_a, ov_b, ld_a, ld_b, we_a, we_b, bs_a, bs_b;
    logic [3:0] en_a, en_b, key_a, key_b;
    logic       m_rdy, m_ov, m_ld, m_we, m_bs;
    logic [3:0] m_en, m_key;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   we_cnt;

    always #5 clk = ~clk;

    assign iv_a = in_valid & ~sel;
    assign iv_b = in_valid & sel;
    assign fl_a = flush & ~sel;
    assign fl_b = flush & sel;

    assign m_rdy = sel ? rdy_b : rdy_a;
    assign m_ov  = sel ? ov_b  : ov_a;
    assign m_ld  = sel ? ld_b  : ld_a;
    assign m_we  = sel ? we_b  : we_a;
    assign m_bs  = sel ? bs_b  : bs_a;
    assign m_en  = sel ? en_b  : en_a;
    assign m_key = sel ? key_b : key_a;

    aes_inv_round_ctrl #(.NR(10), .L(1)) u_dut (
        .i_clock(clk), .i_reset(rst), .i_in_valid(iv_a), .o_in_ready(rdy_a),
        .i_flush(fl_a), .o_out_valid(ov_a), .i_out_ready(out_ready),
        .o_load_state(ld_a), .o_stage_en(en_a), .o_state_we(we_a),
        .o_key_idx(key_a), .o_busy(bs_a)
    );

    aes_inv_round_ctrl #(.NR(14), .L(3)) u_dut14 (
        .i_clock(clk), .i_reset(rst), .i_in_valid(iv_b), .o_in_ready(rdy_b),
        .i_flush(fl_b), .o_out_valid(ov_b), .i_out_ready(out_ready),
        .o_load_state(ld_b), .o_stage_en(en_b), .o_state_we(we_b),
        .o_key_idx(key_b), .o_busy(bs_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_stage(input logic [3:0] en, input logic [3:0] key, input int l);
        exp_t e;
        for (int c = 0; c < l; c++) begin
            e.en  = en;
            e.key = key;
            e.we  = (c == l - 1);
            q.push_back(e);
        end
    endtask

    task automatic push_sched(input int nr, input int l);
        logic [3:0] k;
        k = 4'(nr);
        push_stage(4'b0100, k, l);
        for (int r = nr - 1; r >= 1; r--) begin
            push_stage(4'b0001, k, l);
            push_stage(4'b0010, k, l);
            k = 4'(r);
            push_stage(4'b0100, k, l);
            push_stage(4'b1000, k, l);
        end
        push_stage(4'b0001, k, l);
        push_stage(4'b0010, k, l);
        k = 4'd0;
        push_stage(4'b0100, k, l);
    endtask

    // Called at posedge+1 of the accept cycle (cycle 0)
    task automatic start_block(input int nr, input int l);
        q.delete();
        push_sched(nr, l);
        we_cnt   = 0;
        in_valid = 1'b1;
        @(negedge clk);
        check("accept_in_ready", m_rdy, 1'b1);
        check("accept_load_state", m_ld, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic step_sched(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("sb_nonempty", (q.size() > 0), 1'b1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("stage_en", m_en, e.en);
                check("key_idx", m_key, e.key);
                check("state_we", m_we, e.we);
                check("busy_run", m_bs, 1'b1);
                check("out_valid_run", m_ov, 1'b0);
                if (m_we) we_cnt++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_done();
        @(negedge clk);
        check("done_out_valid", m_ov, 1'b1);
        check("done_in_ready", m_rdy, 1'b0);
        check("done_busy", m_bs, 1'b0);
        check("done_stage_en", m_en, 4'b0000);
        check("done_sb_drained", q.size(), 0);
    endtask

    task automatic release_done();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", m_ov, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_in_ready", m_rdy, 1'b1);
        check("idle_out_valid", m_ov, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, m_rdy, 1'b1);
        check({tag, "_out_valid"}, m_ov, 1'b0);
        check({tag, "_busy"}, m_bs, 1'b0);
        check({tag, "_stage_en"}, m_en, 4'b0000);
        check({tag, "_state_we"}, m_we, 1'b0);
        check({tag, "_load_state"}, m_ld, 1'b0);
        check({tag, "_key_idx"}, m_key, 4'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // NR=10, L=1 full schedule, out_valid in cycle 41
        start_block(10, 1);
        step_sched(40);
        check_done();
        release_done();

        // Backpressure in DONE with a pending new block
        start_block(10, 1);
        step_sched(40);
        check_done();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_out_valid", m_ov, 1'b1);
            check("bp_in_ready", m_rdy, 1'b0);
            check("bp_load_state", m_ld, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_load_state", m_ld, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        start_block(10, 1);
        step_sched(40);
        check_done();
        release_done();

        // NR=14, L=3
        sel = 1'b1;
        start_block(14, 3);
        step_sched(168);
        check("we_pulses_14", we_cnt, 56);
        check_done();
        release_done();
        sel = 1'b0;

        // Flush in cycle 20 of RUN
        start_block(10, 1);
        step_sched(19);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", m_rdy, 1'b1);
        check("flush_busy", m_bs, 1'b0);
        check("flush_stage_en", m_en, 4'b0000);
        check("flush_state_we", m_we, 1'b0);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("flush_no_out_valid", m_ov, 1'b0);
        end
        @(posedge clk); #1;
        start_block(10, 1);
        step_sched(40);
        check_done();
        release_done();

        // Asynchronous reset mid-RUN, asserted off-edge
        start_block(10, 1);
        step_sched(10);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals("post_rst");
        @(posedge clk); #1;
        start_block(10, 1);
        step_sched(40);
        check_done();
        release_done();

        // Flush and in_valid together in IDLE
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        check("fl_iv_load_state", m_ld, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("fl_iv_in_ready", m_rdy, 1'b1);
        check("fl_iv_busy", m_bs, 1'b0);
        check("fl_iv_stage_en", m_en, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_inv_round_ctrl.md
# aes_inv_round_ctrl

Iterative sequencer for the AES inverse-cipher round datapath. It accepts one ciphertext block per transaction and steps the shared stage units through the full inverse-cipher schedule: inverse ShiftRows, inverse SubBytes, AddRoundKey and inverse MixColumns. For each stage it drives one-hot stage enables, the round-key index and state-register write strobes, then presents a done handshake. It sits between the block-level I/O wrapper and the registered inverse-round stage units. It owns no data path, only control.

## Interface
- `NR`, 10: number of rounds (10 for 128-bit keys, 14 for 256-bit keys); legal range 2..14.
- `L`, 1: latency in cycles of every stage unit (registered stages, so ≥1); legal range 1..8.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: ciphertext block offered.
- `in_ready` out 1: controller idle, can accept.
- `flush` in 1: synchronous abort, returns to IDLE.
- `out_valid` out 1: plaintext in the state register is final.
- `out_ready` in 1: consumer takes the result.
- `load_state` out 1: load ciphertext into the state register; equals `in_valid & in_ready`.
- `stage_en` out 4: one-hot stage select, bit0 inv-ShiftRows, bit1 inv-SubBytes, bit2 AddRoundKey, bit3 inv-MixColumns; 0 when not running.
- `state_we` out 1: write the stage result into the state register.
- `key_idx` out 4: round-key index for AddRoundKey.
- `busy` out 1: high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid`, `load_state` pulses and the next state is RUN, at stage index 0 with round = NR.
- **RUN** executes 4·NR stages in this order:
  - ARK(key NR).
  - Then for r = NR−1 down to 1: SR, SB, ARK(key r), IMC.
  - Then SR, SB, ARK(key 0).
  - Each stage lasts exactly L cycles. `stage_en` is held for the whole window. `state_we` is high only on its last cycle.
  - `key_idx` = current round during ARK and holds its last value otherwise.
- **Counters**
  - A stage-cycle counter of width clog2(L+1).
  - A round counter of 4 bits, decremented after each IMC and after the initial ARK.
  - A 2-bit position counter within the round.
  - The round counter never wraps below 0. On completion of ARK(key 0) the next state is DONE.
- **DONE**
  - `out_valid` = 1, held until `out_ready`; the next state is then IDLE.
  - `in_ready` = 0 in DONE, so no same-cycle accept; a new block is accepted at the earliest one cycle after `out_ready`.
- **flush**
  - Any state goes to IDLE next cycle, and all enables and strobes drop.
  - flush wins over `in_valid`, and `load_state` is suppressed in that cycle.
  - flush in DONE discards the result.
- Backpressure exists only in DONE. RUN cannot be stalled.

## Timing
- Reset values: FSM = IDLE, `in_ready` = 1, `out_valid` = 0, `busy` = 0, `stage_en` = 0, `state_we` = 0, `load_state` = 0, `key_idx` = 0.
- Reset mid-RUN abandons the block with no partial `out_valid`.
- Cycle 0 is the accept cycle.
- Stage k (0-based) occupies cycles 1+k·L … (k+1)·L.
- `out_valid` first rises in cycle 4·NR·L + 1.
- Total latency from accept to `out_valid` is 4·NR·L + 1 cycles. Minimum issue interval is 4·NR·L + 2 cycles.
- All outputs except `load_state` are decoded from registered state, with no combinational input→output path.
- `load_state` is combinational from `in_valid`.

## Structure
- Shared package `aes_dec_pkg` holds:
  - the FSM state enum;
  - the stage one-hot constants SR/SB/ARK/IMC;
  - `NR_128` = 10 and `NR_256` = 14;
  - the `key_idx` width.
- One sub-module, `aes_stage_timer`, holds the L-cycle down-counter. It outputs `last` (the final cycle of the window) and reloads on stage start.
- All stage ordering stays in the FSM.

## Test plan
- NR=10, L=1, `in_valid` pulse at cycle 0:
  - `stage_en` sequence is ARK, then (SR, SB, ARK, IMC)×9, then SR, SB, ARK.
  - `key_idx` at each ARK is 10, 9, …, 0.
  - `out_valid` at cycle 41.
- NR=14, L=3:
  - 56 stages, each 3 cycles.
  - `state_we` pulses exactly 56 times, each on the third cycle of its window.
  - `out_valid` at cycle 169.
- `out_ready` held low 5 cycles in DONE:
  - `out_valid` stays 1 and `in_ready` stays 0.
  - A new `in_valid` asserted during DONE is accepted the cycle after `out_ready`.
- `flush` at cycle 20 of RUN:
  - IDLE next cycle, with `stage_en` = 0 and `state_we` = 0.
  - `out_valid` never asserts.
  - A new block then completes with the correct schedule.
- Async `reset` mid-RUN, asserted off-edge:
  - All outputs reach their reset values immediately.
  - After release, `in_ready` = 1 and the next accept yields the full 41-cycle (NR=10, L=1) sequence.
- `flush` and `in_valid` in the same IDLE cycle:
  - No `load_state` and no transition; the controller remains IDLE.
